// File: rtl/uart_rx_top_pkg.sv
// Shared definitions for the UART receive controller: FSM state encoding
// (one-hot, same layout as the transmit controller) and default sizes.
package uart_rx_top_pkg;

  // Data bits per character and FIFO word width.
  localparam int unsigned B_DEF = 8;
  // FIFO address bits; depth is 2**W_DEF.
  localparam int unsigned W_DEF = 5;

  // One-hot receiver states.
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_START = 4'b0010,
    S_DATA  = 4'b0100,
    S_STOP  = 4'b1000
  } rx_state_e;

endpackage

// File: rtl/uart_rx_top_fifo.sv
// Synchronous FIFO shared by the UART transmit and receive controllers.
// The head word is presented combinationally on rdata_o; empty/full are
// registered. A write while full is accepted when a read happens in the
// same cycle, since the read frees a slot on the same edge.
module fifo
  import uart_rx_top_pkg::*;
#(
  parameter int unsigned B = B_DEF,
  parameter int unsigned W = W_DEF
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         wr_i,
  input  logic [B-1:0] wdata_i,
  input  logic         rd_i,
  output logic [B-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam logic [W-1:0] PTR_ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   CNT_ONE   = {{W{1'b0}}, 1'b1};
  localparam logic [W:0]   CNT_ZERO  = {(W+1){1'b0}};
  localparam logic [W:0]   CNT_DEPTH = {1'b1, {W{1'b0}}};

  logic [B-1:0] mem_q [0:(1<<W)-1];
  logic [W-1:0] wptr_q, wptr_d;
  logic [W-1:0] rptr_q, rptr_d;
  logic [W:0]   cnt_q, cnt_d;
  logic         empty_q, empty_d;
  logic         full_q, full_d;
  logic         do_wr_s;
  logic         do_rd_s;

  assign do_rd_s = rd_i & ~empty_q;
  assign do_wr_s = wr_i & (~full_q | do_rd_s);
  assign rdata_o = mem_q[rptr_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;

  // Next pointer / occupancy computation.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_wr_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (do_rd_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    case ({do_wr_s, do_rd_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    empty_d = (cnt_d == CNT_ZERO);
    full_d  = (cnt_d == CNT_DEPTH);
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= {W{1'b0}};
      rptr_q  <= {W{1'b0}};
      cnt_q   <= CNT_ZERO;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    if (do_wr_s) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_rx_top_rx.sv
// 8N1 receiver: 2-flop input synchroniser, start-edge detection, mid-bit
// sampling with a programmable divider, LSB-first shift register. Emits a
// one-cycle done or frame-error tick on the cycle after the stop sample.
module uart_rx
  import uart_rx_top_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        rx_i,
  input  logic        en_i,
  input  logic [15:0] baud_div,
  output logic [7:0]  dout_o,
  output logic        rx_done_tick_o,
  output logic        frame_err_tick_o
);

  logic        sync1_q;
  logic        rx_s;
  logic        rx_s_d;
  logic        sync2_q;
  logic        rx_s_d_q;
  rx_state_e   state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic [15:0] half_s;
  logic [15:0] last_s;

  assign rx_s             = sync2_q;
  assign rx_s_d           = rx_s_d_q;
  assign half_s           = div_q >> 1;
  assign last_s           = div_q - 16'd1;
  assign dout_o           = shreg_q;
  assign rx_done_tick_o   = done_q;
  assign frame_err_tick_o = ferr_q;

  // Synchroniser and edge-detect delay; reset high so reset is not a start edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      rx_s_d_q <= 1'b1;
    end else begin
      sync1_q  <= rx_i;
      sync2_q  <= sync1_q;
      rx_s_d_q <= sync2_q;
    end
  end

  // Receiver next-state, counter and shift-register logic.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_s_d && !rx_s && en_i) begin
          div_d   = baud_div;
          cnt_d   = 16'd0;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == half_s) begin
          cnt_d = 16'd0;
          if (!rx_s) begin
            idx_d   = 3'd0;
            state_d = S_DATA;
          end else begin
            // Line went back high before mid-start: glitch, ignore it.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == last_s) begin
          cnt_d   = 16'd0;
          shreg_d = {rx_s, shreg_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == last_s) begin
          // Return to idle mid stop bit so back-to-back frames are caught.
          cnt_d   = 16'd0;
          done_d  = rx_s;
          ferr_d  = ~rx_s;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      div_q   <= 16'd0;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shreg_q <= 8'd0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

endmodule

// File: rtl/uart_rx_top.sv
// UART receive controller top: receiver, 32-entry byte FIFO, read-data
// register and sticky overrun / frame-error status flags.
module uart_rx_top
  import uart_rx_top_pkg::*;
#(
  parameter int unsigned B = B_DEF,
  parameter int unsigned W = W_DEF
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         uart_rx_i,
  input  logic         UART_Kontrol_Yazmaci_rx_Active,
  input  logic [15:0]  baud_div,
  input  logic         UART_Veri_Okuma_Yazmaci_enable,
  input  logic         UART_Durum_Temizle_enable,
  output logic [B-1:0] UART_Veri_Okuma_Yazmaci_rdata,
  output logic         UART_Durum_Yazmaci_rx_full,
  output logic         UART_Durum_Yazmaci_rx_empty,
  output logic         UART_Durum_Yazmaci_rx_overrun,
  output logic         UART_Durum_Yazmaci_rx_frame_err
);

  logic [7:0]   rx_byte_s;
  logic         rx_done_s;
  logic         rx_ferr_s;
  logic [B-1:0] fifo_head_s;
  logic         fifo_empty_s;
  logic         fifo_full_s;
  logic         fifo_rd_s;
  logic         fifo_wr_s;
  logic [B-1:0] rdata_q, rdata_d;
  logic         ovr_q, ovr_d;
  logic         ferr_q, ferr_d;

  uart_rx u_rx (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .rx_i             (uart_rx_i),
    .en_i             (UART_Kontrol_Yazmaci_rx_Active),
    .baud_div         (baud_div),
    .dout_o           (rx_byte_s),
    .rx_done_tick_o   (rx_done_s),
    .frame_err_tick_o (rx_ferr_s)
  );

  // A pop in the push cycle frees a slot, so the push is still accepted.
  assign fifo_rd_s = UART_Veri_Okuma_Yazmaci_enable & ~fifo_empty_s;
  assign fifo_wr_s = rx_done_s & (~fifo_full_s | fifo_rd_s);

  fifo #(
    .B (B),
    .W (W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .wr_i    (fifo_wr_s),
    .wdata_i (rx_byte_s),
    .rd_i    (fifo_rd_s),
    .rdata_o (fifo_head_s),
    .empty_o (fifo_empty_s),
    .full_o  (fifo_full_s)
  );

  // Read-data capture and sticky flags; a set wins over a clear.
  always_comb begin
    rdata_d = rdata_q;
    ovr_d   = ovr_q;
    ferr_d  = ferr_q;
    if (fifo_rd_s) begin
      rdata_d = fifo_head_s;
    end else begin
      rdata_d = rdata_q;
    end
    if (rx_done_s && fifo_full_s && !fifo_rd_s) begin
      ovr_d = 1'b1;
    end else if (UART_Durum_Temizle_enable) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
    if (rx_ferr_s) begin
      ferr_d = 1'b1;
    end else if (UART_Durum_Temizle_enable) begin
      ferr_d = 1'b0;
    end else begin
      ferr_d = ferr_q;
    end
  end

  // Read-data and status flag registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdata_q <= {B{1'b0}};
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign UART_Veri_Okuma_Yazmaci_rdata   = rdata_q;
  assign UART_Durum_Yazmaci_rx_full      = fifo_full_s;
  assign UART_Durum_Yazmaci_rx_empty     = fifo_empty_s;
  assign UART_Durum_Yazmaci_rx_overrun   = ovr_q;
  assign UART_Durum_Yazmaci_rx_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: directed scenarios plus randomized
// frames, all compared against a byte-queue model of the receiver.
module tb_uart_rx_top;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        uart_rx_i = 1'b1;
  logic        rx_active = 1'b0;
  logic [15:0] baud_div = 16'd16;
  logic        rd_en = 1'b0;
  logic        clr_en = 1'b0;
  logic [7:0]  rdata;
  logic        full, empty, ovr, ferr;

  uart_rx_top dut (
    .clk_i                           (clk_i),
    .rstn_i                          (rstn_i),
    .uart_rx_i                       (uart_rx_i),
    .UART_Kontrol_Yazmaci_rx_Active  (rx_active),
    .baud_div                        (baud_div),
    .UART_Veri_Okuma_Yazmaci_enable  (rd_en),
    .UART_Durum_Temizle_enable       (clr_en),
    .UART_Veri_Okuma_Yazmaci_rdata   (rdata),
    .UART_Durum_Yazmaci_rx_full      (full),
    .UART_Durum_Yazmaci_rx_empty     (empty),
    .UART_Durum_Yazmaci_rx_overrun   (ovr),
    .UART_Durum_Yazmaci_rx_frame_err (ferr)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Behavioural model: received-byte queue, last popped byte, sticky flags.
  logic [7:0] mq[$];
  logic [7:0] m_rdata = 8'h00;
  bit         m_ovr = 1'b0;
  bit         m_ferr = 1'b0;
  bit         chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Compare outputs with the model whenever the line is quiet.
  always @(negedge clk_i) begin
    if (chk_en && rstn_i && !rd_en && !clr_en) begin
      check("cmp_empty", {31'd0, empty}, {31'd0, (mq.size() == 0)});
      check("cmp_full", {31'd0, full}, {31'd0, (mq.size() == 32)});
      check("cmp_rdata", {24'd0, rdata}, {24'd0, m_rdata});
      check("cmp_overrun", {31'd0, ovr}, {31'd0, m_ovr});
      check("cmp_frame_err", {31'd0, ferr}, {31'd0, m_ferr});
    end
  end

  // Drive one 8N1 frame of d cycles per bit; update the model at its end.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int d,
                            input bit scr, input bit drp);
    logic [9:0] fr;
    bit acc;
    fr = {stop_ok, b, 1'b0};
    chk_en = 1'b0;
    acc = rx_active;
    baud_div = 16'(d);
    for (int i = 0; i < 10; i++) begin
      uart_rx_i = fr[i];
      if (i == 4 && drp) rx_active = 1'b0;
      if (i == 0 && scr) begin
        cyc(5);
        baud_div = 16'($urandom_range(16, 65535));
        cyc(d - 5);
      end else begin
        cyc(d);
      end
    end
    uart_rx_i = 1'b1;
    if (acc) begin
      if (!stop_ok) m_ferr = 1'b1;
      else if (mq.size() < 32) mq.push_back(b);
      else m_ovr = 1'b1;
    end
    chk_en = 1'b1;
  endtask

  task automatic do_read();
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    if (mq.size() > 0) m_rdata = mq.pop_front();
  endtask

  task automatic do_clear();
    clr_en = 1'b1;
    cyc(1);
    clr_en = 1'b0;
    m_ovr = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] burst [4];
    burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55; burst[3] = 8'h3C;

    // Reset state.
    cyc(3);
    check("rst_rdata", {24'd0, rdata}, 32'h0);
    check("rst_empty", {31'd0, empty}, 32'h1);
    check("rst_full", {31'd0, full}, 32'h0);
    check("rst_flags", {30'd0, ovr, ferr}, 32'h0);
    rstn_i = 1'b1;
    rx_active = 1'b1;
    cyc(5);
    chk_en = 1'b1;

    // Single byte at 115200 baud from 100 MHz.
    send_frame(8'hA5, 1'b1, 868, 1'b0, 1'b0);
    cyc(4);
    check("single_empty", {31'd0, empty}, 32'h0);
    do_read();
    check("single_rdata", {24'd0, rdata}, 32'hA5);
    check("single_empty_after", {31'd0, empty}, 32'h1);

    // Back-to-back burst with no idle gap.
    for (int i = 0; i < 4; i++) send_frame(burst[i], 1'b1, 16, 1'b0, 1'b0);
    cyc(4);
    for (int i = 0; i < 4; i++) begin
      do_read();
      check("burst_rdata", {24'd0, rdata}, {24'd0, burst[i]});
    end
    check("burst_flags", {30'd0, ovr, ferr}, 32'h0);

    // Glitch: 100-cycle low pulse at divisor 868.
    chk_en = 1'b0;
    baud_div = 16'd868;
    uart_rx_i = 1'b0;
    cyc(100);
    uart_rx_i = 1'b1;
    cyc(1000);
    chk_en = 1'b1;
    check("glitch_empty", {31'd0, empty}, 32'h1);
    check("glitch_ferr", {31'd0, ferr}, 32'h0);

    // Frame error, then a clean byte, then clear.
    send_frame(8'h81, 1'b0, 16, 1'b0, 1'b0);
    cyc(4);
    check("ferr_set", {31'd0, ferr}, 32'h1);
    check("ferr_empty", {31'd0, empty}, 32'h1);
    send_frame(8'h42, 1'b1, 16, 1'b0, 1'b0);
    cyc(4);
    do_read();
    check("ferr_next_rdata", {24'd0, rdata}, 32'h42);
    do_clear();
    cyc(1);
    check("ferr_cleared", {31'd0, ferr}, 32'h0);

    // Overrun: 33 bytes, no reads.
    for (int i = 0; i < 33; i++) send_frame(8'(i), 1'b1, 16, 1'b0, 1'b0);
    cyc(4);
    check("ovr_full", {31'd0, full}, 32'h1);
    check("ovr_set", {31'd0, ovr}, 32'h1);
    for (int i = 0; i < 32; i++) begin
      do_read();
      check("ovr_rdata", {24'd0, rdata}, i);
    end
    check("ovr_drained", {31'd0, empty}, 32'h1);
    do_clear();

    // Full FIFO with a pop in the push cycle of the 33rd byte.
    for (int i = 0; i < 32; i++) send_frame(8'(i), 1'b1, 16, 1'b0, 1'b0);
    cyc(4);
    fork
      send_frame(8'h20, 1'b1, 16, 1'b0, 1'b0);
      begin
        cyc(4 + 8 + 9 * 16);
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        m_rdata = mq.pop_front();
      end
    join
    cyc(4);
    check("simul_full", {31'd0, full}, 32'h1);
    check("simul_ovr", {31'd0, ovr}, 32'h0);
    check("simul_rdata", {24'd0, rdata}, 32'h00);
    for (int i = 1; i <= 32; i++) begin
      do_read();
      check("simul_order", {24'd0, rdata}, i);
    end

    // Reset in the middle of a frame with one byte buffered.
    send_frame(8'h99, 1'b1, 16, 1'b0, 1'b0);
    cyc(2);
    chk_en = 1'b0;
    uart_rx_i = 1'b0;
    cyc(50);
    rstn_i = 1'b0;
    uart_rx_i = 1'b1;
    mq.delete();
    m_rdata = 8'h00;
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    cyc(3);
    rstn_i = 1'b1;
    cyc(1);
    check("rstmid_empty", {31'd0, empty}, 32'h1);
    check("rstmid_rdata", {24'd0, rdata}, 32'h0);
    cyc(400);
    check("rstmid_no_spurious", {31'd0, empty}, 32'h1);
    chk_en = 1'b1;

    // Randomized frames: divisor, data, stop, enable, mid-frame changes.
    for (int it = 0; it < 40; it++) begin
      int d;
      logic [7:0] b;
      bit ok, act, scr, drp;
      d = $urandom_range(16, 40);
      b = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      act = ($urandom_range(0, 5) != 0);
      scr = ($urandom_range(0, 2) == 0);
      drp = act && ($urandom_range(0, 4) == 0);
      rx_active = act;
      send_frame(b, ok, d, scr, drp);
      if (!ok || $urandom_range(0, 1) == 1) cyc($urandom_range(2, 20));
      if ($urandom_range(0, 2) == 0) do_read();
      if ($urandom_range(0, 9) == 0) do_clear();
    end
    rx_active = 1'b1;
    cyc(4);
    while (mq.size() > 0) do_read();
    cyc(2);
    check("rand_final_empty", {31'd0, empty}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
